// File: rtl/abr_prim_cdc_delay_pkg.sv
// Shared types, constants and LFSR step function for the CDC delay-injection sequencer.
package abr_prim_cdc_delay_pkg;

    typedef enum logic [1:0] {
        CdcDlyOff    = 2'd0,
        CdcDlyRand   = 2'd1,
        CdcDlyAlways = 2'd2,
        CdcDlyRsvd   = 2'd3
    } cdc_delay_mode_e;

    localparam int unsigned LfsrWidth = 32;
    localparam logic [LfsrWidth-1:0] LfsrMask = 32'h8020_0003;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] state);
        lfsr_next = (state >> 1) ^ ({LfsrWidth{state[0]}} & LfsrMask);
    endfunction

endpackage

// File: rtl/abr_prim_cdc_delay_lfsr.sv
// 32-bit Galois LFSR with step enable, seed load and zero-seed fallback to the reset seed.
module abr_prim_cdc_delay_lfsr
    import abr_prim_cdc_delay_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] LfsrSeed = 32'hACE1_2357
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic                 en_i,
    input  logic                 seed_we_i,
    input  logic [LfsrWidth-1:0] seed_i,
    output logic [LfsrWidth-1:0] lfsr_o
);

    logic [LfsrWidth-1:0] lfsr_q;

    // A zero seed would lock the register, so it is replaced by the reset seed.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_q <= LfsrSeed;
        end else if (seed_we_i) begin
            lfsr_q <= (seed_i == '0) ? LfsrSeed : seed_i;
        end else if (en_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/abr_prim_cdc_delay_ctrl.sv
// Per-bit CDC delay injection: a detected transition may be hidden from the first sync flop
// for exactly one cycle, chosen by mode and an LFSR-driven probability.
module abr_prim_cdc_delay_ctrl
    import abr_prim_cdc_delay_pkg::*;
#(
    parameter int unsigned          DataWidth = 8,
    parameter int unsigned          CntWidth  = 16,
    parameter logic [LfsrWidth-1:0] LfsrSeed  = 32'hACE1_2357
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic                 en_i,
    input  logic [1:0]           mode_i,
    input  logic [7:0]           thresh_i,
    input  logic                 seed_we_i,
    input  logic [31:0]          seed_i,
    input  logic                 cnt_clr_i,
    input  logic [DataWidth-1:0] src_data_i,
    input  logic [DataWidth-1:0] prev_data_i,
    output logic [DataWidth-1:0] data_sel_o,
    output logic [DataWidth-1:0] dst_data_o,
    output logic [CntWidth-1:0]  delay_cnt_o
);

    cdc_delay_mode_e              mode;
    logic [DataWidth-1:0]         src_q;
    logic [DataWidth-1:0]         hold_q;
    logic                         first_q;
    logic [DataWidth-1:0]         chg;
    logic [DataWidth-1:0]         pick;
    logic [DataWidth-1:0]         sel;
    logic [LfsrWidth-1:0]         lfsr_q;
    logic [DataWidth-1:0][7:0]    lfsr_byte;
    logic [CntWidth-1:0]          delay_cnt_q;

    assign mode = cdc_delay_mode_e'(mode_i);

    abr_prim_cdc_delay_lfsr #(
        .LfsrSeed (LfsrSeed)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_b     (rst_b),
        .en_i      (en_i),
        .seed_we_i (seed_we_i),
        .seed_i    (seed_i),
        .lfsr_o    (lfsr_q)
    );

    // Each bit draws its own byte from the LFSR, wrapping around past bit 31.
    for (genvar g = 0; g < DataWidth; g++) begin : g_byte
        for (genvar j = 0; j < 8; j++) begin : g_bit
            assign lfsr_byte[g][j] = lfsr_q[(8*g+j) % LfsrWidth];
        end
    end

    always_comb begin
        pick = '0;
        for (int i = 0; i < DataWidth; i++) begin
            unique case (mode)
                CdcDlyAlways: pick[i] = 1'b1;
                CdcDlyRand:   pick[i] = (lfsr_byte[i] < thresh_i);
                default:      pick[i] = 1'b0;
            endcase
        end
    end

    assign chg = (src_data_i ^ src_q) & {DataWidth{~first_q}};
    assign sel = {DataWidth{en_i}} & ~hold_q & chg & pick;

    // A delayed bit spends exactly one cycle in HOLD, which blocks a second consecutive delay.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            src_q   <= '0;
            first_q <= 1'b1;
            hold_q  <= '0;
        end else begin
            src_q   <= src_data_i;
            first_q <= 1'b0;
            hold_q  <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            delay_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            delay_cnt_q <= '0;
        end else if ((|sel) && (delay_cnt_q != {CntWidth{1'b1}})) begin
            delay_cnt_q <= delay_cnt_q + 1'b1;
        end
    end

    assign data_sel_o  = sel;
    assign dst_data_o  = (prev_data_i & sel) | (src_data_i & ~sel);
    assign delay_cnt_o = delay_cnt_q;

endmodule

// File: tb/tb_abr_prim_cdc_delay_ctrl.sv
// Randomized and directed checks of the CDC delay sequencer against a cycle-indexed
// behavioural model (delay eligibility tracked by the cycle of each bit's last delay).
module tb_abr_prim_cdc_delay_ctrl;
    import abr_prim_cdc_delay_pkg::*;

    localparam int          DW   = 8;
    localparam int          CW   = 6;
    localparam logic [31:0] SEED = 32'hACE1_2357;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_b = 1'b0;
    logic          en_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [7:0]    thresh_i = 8'd0;
    logic          seed_we_i = 1'b0;
    logic [31:0]   seed_i = 32'd0;
    logic          cnt_clr_i = 1'b0;
    logic [DW-1:0] src_data_i = '0;
    logic [DW-1:0] prev_data_i = '0;
    logic [DW-1:0] data_sel_o;
    logic [DW-1:0] dst_data_o;
    logic [CW-1:0] delay_cnt_o;

    abr_prim_cdc_delay_ctrl #(
        .DataWidth (DW),
        .CntWidth  (CW),
        .LfsrSeed  (SEED)
    ) dut (
        .clk_i       (clk_i),
        .rst_b       (rst_b),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .thresh_i    (thresh_i),
        .seed_we_i   (seed_we_i),
        .seed_i      (seed_i),
        .cnt_clr_i   (cnt_clr_i),
        .src_data_i  (src_data_i),
        .prev_data_i (prev_data_i),
        .data_sel_o  (data_sel_o),
        .dst_data_o  (dst_data_o),
        .delay_cnt_o (delay_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0]   m_lfsr;
    logic [DW-1:0] m_src;
    bit            m_first;
    int            m_last_delay [DW];
    int            m_cnt;
    int            cyc = 0;
    logic [DW-1:0] exp_sel;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] refStep(input logic [31:0] s);
        if (s % 2 == 1) return (s >> 1) ^ 32'h8020_0003;
        return s >> 1;
    endfunction

    function automatic int refByte(input int i);
        int v = 0;
        for (int j = 0; j < 8; j++)
            if (m_lfsr[(8*i+j) % 32]) v += (1 << j);
        return v;
    endfunction

    function automatic logic [DW-1:0] predictSel();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < DW; i++) begin
            bit changed = !m_first && (src_data_i[i] != m_src[i]);
            bit chosen;
            case (mode_i)
                2'd2:    chosen = 1'b1;
                2'd1:    chosen = (refByte(i) < int'(thresh_i));
                default: chosen = 1'b0;
            endcase
            s[i] = en_i && changed && chosen && (m_last_delay[i] != cyc - 1);
        end
        return s;
    endfunction

    task automatic modelReset();
        m_lfsr  = SEED;
        m_src   = '0;
        m_first = 1'b1;
        m_cnt   = 0;
        for (int i = 0; i < DW; i++) m_last_delay[i] = -10;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] src, input logic [DW-1:0] prev, input logic en,
                                 input logic [1:0] mode, input logic [7:0] thresh, input logic clr,
                                 input logic swe, input logic [31:0] seed);
        src_data_i  = src;
        prev_data_i = prev;
        en_i        = en;
        mode_i      = mode;
        thresh_i    = thresh;
        cnt_clr_i   = clr;
        seed_we_i   = swe;
        seed_i      = seed;
        #1;
        exp_sel = predictSel();
        checkOutput("data_sel", 64'(data_sel_o), 64'(exp_sel));
        checkOutput("dst_data", 64'(dst_data_o), 64'((prev & exp_sel) | (src & ~exp_sel)));
        checkOutput("delay_cnt", 64'(delay_cnt_o), 64'(m_cnt));
    endtask

    task automatic advanceClock();
        @(posedge clk_i);
        for (int i = 0; i < DW; i++) if (exp_sel[i]) m_last_delay[i] = cyc;
        if (cnt_clr_i) m_cnt = 0;
        else if (exp_sel != '0 && m_cnt < CMAX) m_cnt++;
        if (seed_we_i) m_lfsr = (seed_i == 0) ? SEED : seed_i;
        else if (en_i) m_lfsr = refStep(m_lfsr);
        m_src   = src_data_i;
        m_first = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic doReset();
        rst_b = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rst_sel", 64'(data_sel_o), 64'd0);
        checkOutput("rst_cnt", 64'(delay_cnt_o), 64'd0);
        rst_b = 1'b1;
    endtask

    logic [DW-1:0] s;
    int            delayed;
    int            toggles;
    int            guard;

    initial begin
        $display("[TB] start");
        src_data_i = 8'hFF;
        doReset();

        // First post-reset cycle: the apparent 00->FF change is masked.
        applyStimulus(8'hFF, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("first_mask_sel", 64'(data_sel_o), 64'd0);
        advanceClock();

        // ALWAYS: 00 -> 05 is delayed one cycle.
        src_data_i = 8'h00;
        doReset();
        applyStimulus(8'h00, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        advanceClock();
        applyStimulus(8'h05, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("always_sel", 64'(data_sel_o), 64'h05);
        checkOutput("always_dst", 64'(dst_data_o), 64'h00);
        advanceClock();
        applyStimulus(8'h05, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("always_sel_next", 64'(data_sel_o), 64'h00);
        checkOutput("always_dst_next", 64'(dst_data_o), 64'h05);
        checkOutput("always_cnt", 64'(delay_cnt_o), 64'd1);
        advanceClock();

        // Back-to-back toggles of bit0.
        applyStimulus(8'h04, 8'h05, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("b2b_first", 64'(data_sel_o), 64'h01);
        advanceClock();
        applyStimulus(8'h05, 8'h04, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("b2b_hold", 64'(data_sel_o), 64'h00);
        advanceClock();
        applyStimulus(8'h04, 8'h05, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("b2b_third", 64'(data_sel_o), 64'h01);
        advanceClock();

        // Enable low: pass-through in the same cycle.
        applyStimulus(8'hF0, 8'h0F, 1'b0, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("en_low_sel", 64'(data_sel_o), 64'h00);
        checkOutput("en_low_dst", 64'(dst_data_o), 64'hF0);
        advanceClock();

        // RAND with zero threshold never delays.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(DW'($urandom), DW'($urandom), 1'b1, CdcDlyRand, 8'd0, 1'b0, 1'b0, 32'd0);
            checkOutput("thresh0_sel", 64'(data_sel_o), 64'h00);
            advanceClock();
        end

        // Zero seed falls back to the reset seed.
        applyStimulus(src_data_i, 8'h00, 1'b1, CdcDlyOff, 8'd0, 1'b0, 1'b1, 32'd0);
        advanceClock();
        checkOutput("seed_zero_fallback", 64'(dut.lfsr_q), 64'(SEED));

        // RAND thresh 255 from seed 1: each bit toggles every other cycle.
        applyStimulus(src_data_i, 8'h00, 1'b1, CdcDlyRand, 8'd255, 1'b0, 1'b1, 32'd1);
        advanceClock();
        s = src_data_i;
        delayed = 0;
        toggles = 0;
        for (int k = 0; k < 2500; k++) begin
            if (k % 2 == 0) begin
                s = ~s;
                toggles += DW;
            end
            applyStimulus(s, ~s, 1'b1, CdcDlyRand, 8'd255, 1'b0, 1'b0, 32'd0);
            delayed += $countones(data_sel_o);
            advanceClock();
        end
        checkOutput("rand_toggle_count", 64'(toggles), 64'd10000);
        checkOutput("rand_rate_above_99", 64'(delayed * 100 > toggles * 99), 64'd1);

        // Saturation of the counter, then clear beating a delay event.
        guard = 0;
        s = src_data_i;
        while (m_cnt < CMAX && guard < 400) begin
            s[0] = ~s[0];
            applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
            advanceClock();
            applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
            advanceClock();
            guard++;
        end
        checkOutput("sat_reached", 64'(delay_cnt_o), 64'(CMAX));
        s[1] = ~s[1];
        applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        advanceClock();
        applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("sat_hold", 64'(delay_cnt_o), 64'(CMAX));
        advanceClock();
        s[2] = ~s[2];
        applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("clr_event_sel", 64'(data_sel_o), 64'h04);
        advanceClock();
        applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("clr_priority", 64'(delay_cnt_o), 64'd0);
        advanceClock();

        // Async reset while bits 0-3 are in HOLD and bits 4-7 are being delayed.
        s = s ^ 8'h0F;
        applyStimulus(s, 8'h00, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("pre_hold_sel", 64'(data_sel_o), 64'h0F);
        advanceClock();
        s = s ^ 8'hF0;
        applyStimulus(s, ~s, 1'b1, CdcDlyAlways, 8'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("hold_q_set", 64'(dut.hold_q), 64'h0F);
        rst_b = 1'b0;
        #1;
        checkOutput("async_rst_sel", 64'(data_sel_o), 64'h00);
        checkOutput("async_rst_dst", 64'(dst_data_o), 64'(s));
        checkOutput("async_rst_hold", 64'(dut.hold_q), 64'h00);
        modelReset();
        #1;
        rst_b = 1'b1;

        // Randomized operation against the model.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] sd;
            sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            s  = src_data_i ^ (DW'($urandom) & DW'($urandom));
            applyStimulus(s, DW'($urandom), ($urandom_range(0, 9) != 0), 2'($urandom),
                          8'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0), sd);
            advanceClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
